// File: rtl/blake2s_block_sched_pkg.sv
// Shared constants and state encoding for the BLAKE2s block scheduler.
package blake2s_pkg;

  localparam int BLOCK_BYTES   = 64;
  localparam int KEY_MAX_BYTES = 32;
  localparam int IDX_W         = $clog2(BLOCK_BYTES);
  localparam int LEN_W         = $clog2(KEY_MAX_BYTES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    KEY,
    MSG,
    PAD,
    WAIT_HASH
  } state_t;

endpackage

// File: rtl/blake2s_block_sched_if.sv
// Byte-stream, configuration and core-side signals of the block scheduler.
interface blake2s_block_sched_if #(
  parameter int LL_W = 64
);
  import blake2s_pkg::*;

  logic             start_i;
  logic [LEN_W-1:0] kk_i;
  logic [LEN_W-1:0] nn_i;
  logic [LL_W-1:0]  ll_i;
  logic             in_valid_i;
  logic [7:0]       in_data_i;
  logic             in_ready_o;
  logic             core_ready_i;
  logic             h_v_i;
  logic [LEN_W-1:0] kk_o;
  logic [LEN_W-1:0] nn_o;
  logic [LL_W-1:0]  ll_o;
  logic             data_v_o;
  logic [7:0]       data_o;
  logic [IDX_W-1:0] data_idx_o;
  logic             block_first_o;
  logic             block_last_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, kk_i, nn_i, ll_i, in_valid_i, in_data_i, core_ready_i, h_v_i,
    input  in_ready_o, kk_o, nn_o, ll_o, data_v_o, data_o, data_idx_o,
           block_first_o, block_last_o, busy_o, done_o
  );

  modport slave (
    input  start_i, kk_i, nn_i, ll_i, in_valid_i, in_data_i, core_ready_i, h_v_i,
    output in_ready_o, kk_o, nn_o, ll_o, data_v_o, data_o, data_idx_o,
           block_first_o, block_last_o, busy_o, done_o
  );

endinterface

// File: rtl/blake2s_block_sched.sv
// Splits key + message bytes into zero-padded 64-byte BLAKE2s blocks for the
// hash core, tagging each block with first/last flags, then waits for the digest.
module blake2s_block_sched #(
  parameter int BLOCK_BYTES = blake2s_pkg::BLOCK_BYTES,
  parameter int LL_W        = 64
) (
  input logic                 clk,
  input logic                 reset,
  blake2s_block_sched_if.slave bus
);
  import blake2s_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BLOCK_BYTES - 1);
  localparam logic [LL_W-1:0]  BLOCK_LEN = LL_W'(BLOCK_BYTES);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] kk_q, kk_d, nn_q, nn_d;
  logic [LEN_W-1:0] key_cnt_q, key_cnt_d, hash_cnt_q, hash_cnt_d;
  logic [LL_W-1:0]  ll_q, ll_d, rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d, data_idx_q, data_idx_d;
  logic [7:0]       data_q, data_d;
  logic             data_v_q, data_v_d, done_q, done_d;
  logic             cur_first_q, cur_first_d, cur_last_q, cur_last_d;
  logic             first_q, first_d, last_q, last_d;
  logic             in_phase, beat, wrap;
  logic [LL_W-1:0]  rem_dec;

  assign in_phase = (state_q == KEY) || (state_q == MSG);
  assign beat     = (in_phase && bus.in_valid_i && bus.core_ready_i)
                  || ((state_q == PAD) && bus.core_ready_i);
  assign wrap     = (idx_q == LAST_IDX);
  assign rem_dec  = rem_q - LL_W'(1);

  assign bus.in_ready_o    = in_phase && bus.core_ready_i;
  assign bus.kk_o          = kk_q;
  assign bus.nn_o          = nn_q;
  assign bus.ll_o          = ll_q;
  assign bus.data_v_o      = data_v_q;
  assign bus.data_o        = data_q;
  assign bus.data_idx_o    = data_idx_q;
  assign bus.block_first_o = first_q;
  assign bus.block_last_o  = last_q;
  assign bus.busy_o        = (state_q != IDLE);
  assign bus.done_o        = done_q;

  // cur_first/cur_last describe the block being filled; they are copied into the
  // output flags with each beat so beat 63 still carries its own block's flags.
  always_comb begin
    state_d     = state_q;
    kk_d        = kk_q;
    nn_d        = nn_q;
    ll_d        = ll_q;
    rem_d       = rem_q;
    key_cnt_d   = key_cnt_q;
    hash_cnt_d  = hash_cnt_q;
    idx_d       = idx_q;
    data_idx_d  = data_idx_q;
    data_d      = data_q;
    data_v_d    = beat;
    done_d      = 1'b0;
    cur_first_d = cur_first_q;
    cur_last_d  = cur_last_q;
    first_d     = first_q;
    last_d      = last_q;

    if (beat) begin
      data_d     = (state_q == PAD) ? 8'h00 : bus.in_data_i;
      data_idx_d = idx_q;
      first_d    = cur_first_q;
      last_d     = cur_last_q;
      idx_d      = wrap ? '0 : idx_q + IDX_W'(1);
      if (wrap) begin
        cur_first_d = 1'b0;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          kk_d        = bus.kk_i;
          nn_d        = bus.nn_i;
          ll_d        = bus.ll_i;
          rem_d       = bus.ll_i;
          idx_d       = '0;
          key_cnt_d   = '0;
          hash_cnt_d  = '0;
          cur_first_d = 1'b1;
          cur_last_d  = (bus.kk_i == '0) ? (bus.ll_i <= BLOCK_LEN) : (bus.ll_i == '0);
          if (bus.kk_i != '0) begin
            state_d = KEY;
          end else if (bus.ll_i != '0) begin
            state_d = MSG;
          end else begin
            state_d = PAD;
          end
        end
      end
      KEY: begin
        if (beat) begin
          key_cnt_d = key_cnt_q + LEN_W'(1);
          if (key_cnt_d == kk_q) begin
            state_d = PAD;
          end
        end
      end
      MSG: begin
        // A message ending exactly on a block boundary needs no padding beats.
        if (beat) begin
          rem_d = rem_dec;
          if (rem_dec == '0) begin
            state_d = wrap ? WAIT_HASH : PAD;
          end else if (wrap) begin
            cur_last_d = (rem_dec <= BLOCK_LEN);
          end
        end
      end
      PAD: begin
        if (beat && wrap) begin
          if (rem_q != '0) begin
            state_d    = MSG;
            cur_last_d = (rem_q <= BLOCK_LEN);
          end else begin
            state_d = WAIT_HASH;
          end
        end
      end
      WAIT_HASH: begin
        if (bus.h_v_i) begin
          hash_cnt_d = hash_cnt_q + LEN_W'(1);
          if (hash_cnt_d == nn_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      kk_q        <= '0;
      nn_q        <= '0;
      ll_q        <= '0;
      rem_q       <= '0;
      key_cnt_q   <= '0;
      hash_cnt_q  <= '0;
      idx_q       <= '0;
      data_idx_q  <= '0;
      data_q      <= '0;
      data_v_q    <= 1'b0;
      done_q      <= 1'b0;
      cur_first_q <= 1'b0;
      cur_last_q  <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      kk_q        <= kk_d;
      nn_q        <= nn_d;
      ll_q        <= ll_d;
      rem_q       <= rem_d;
      key_cnt_q   <= key_cnt_d;
      hash_cnt_q  <= hash_cnt_d;
      idx_q       <= idx_d;
      data_idx_q  <= data_idx_d;
      data_q      <= data_d;
      data_v_q    <= data_v_d;
      done_q      <= done_d;
      cur_first_q <= cur_first_d;
      cur_last_q  <= cur_last_d;
      first_q     <= first_d;
      last_q      <= last_d;
    end
  end

endmodule

// File: tb/tb_blake2s_block_sched.sv
// Scoreboard bench: a block-list model queues every expected core beat
// ({data, idx, first, last}); a negedge monitor pops and compares them.
module tb_blake2s_block_sched;
  import blake2s_pkg::*;

  logic clk;
  logic reset;
  int   checkCount;
  int   errorCount;
  int   readyCount;
  logic [15:0] sbq[$];

  blake2s_block_sched_if #(.LL_W(64)) bus ();

  blake2s_block_sched #(.BLOCK_BYTES(64), .LL_W(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [7:0] streamByte(input int p, input int kk);
    if (p < kk) return 8'(8'h80 + p);
    return 8'(8'h61 + (p - kk));
  endfunction

  // Independent block-list model: optional key block, then ll bytes zero-padded
  // to whole blocks, or one all-zero block when there is neither key nor message.
  task automatic pushExpected(input int kk, input int ll);
    int keyBlocks, nBlocks, m;
    logic [7:0] d;
    keyBlocks = (kk > 0) ? 1 : 0;
    nBlocks   = keyBlocks + (ll + 63) / 64;
    if (nBlocks == 0) nBlocks = 1;
    for (int b = 0; b < nBlocks; b++) begin
      for (int i = 0; i < 64; i++) begin
        if (keyBlocks == 1 && b == 0) begin
          d = (i < kk) ? streamByte(i, kk) : 8'h00;
        end else begin
          m = (b - keyBlocks) * 64 + i;
          d = (m < ll) ? streamByte(kk + m, kk) : 8'h00;
        end
        sbq.push_back({d, 6'(i), b == 0, b == nBlocks - 1});
      end
    end
  endtask

  always @(negedge clk) begin
    if (bus.in_ready_o) readyCount++;
    if (bus.data_v_o) begin
      if (sbq.size() == 0) begin
        checkOutput("spurious_beat", 64'(bus.data_v_o), 64'd0);
      end else begin
        checkOutput("beat", 64'({bus.data_o, bus.data_idx_o, bus.block_first_o,
                                 bus.block_last_o}), 64'(sbq.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input int kk, input int nn, input int ll,
                               input int stallAt, input int resetAt, input bit stray);
    int  p, cyc, total;
    bit  accepted, aborted;
    total   = kk + ll;
    aborted = 1'b0;
    pushExpected(kk, ll);

    @(negedge clk);
    bus.start_i = 1'b1;
    bus.kk_i    = 6'(kk);
    bus.nn_i    = 6'(nn);
    bus.ll_i    = 64'(ll);
    @(negedge clk);
    bus.start_i = 1'b0;
    #1;
    checkOutput("cfg_kk", 64'(bus.kk_o), 64'(kk));
    checkOutput("cfg_ll", 64'(bus.ll_o), 64'(ll));
    checkOutput("busy_start", 64'(bus.busy_o), 64'd1);

    p   = 0;
    cyc = 0;
    while (p < total && cyc < 2000 && !aborted) begin
      @(negedge clk);
      bus.core_ready_i = 1'b1;
      bus.in_valid_i   = 1'b1;
      bus.in_data_i    = streamByte(p, kk);
      bus.start_i      = 1'b0;
      bus.kk_i         = 6'(kk);
      bus.ll_i         = 64'(ll);
      if (stray && p == 10) begin
        bus.start_i = 1'b1;
        bus.kk_i    = 6'd5;
        bus.ll_i    = 64'd7;
      end
      #1;
      accepted = bus.in_ready_o;
      @(posedge clk);
      cyc++;
      if (accepted) begin
        if (p == resetAt) begin
          @(negedge clk);
          #2;
          reset = 1'b1;
          #1;
          checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
          checkOutput("rst_data_v", 64'(bus.data_v_o), 64'd0);
          checkOutput("rst_ll_o", 64'(bus.ll_o), 64'd0);
          checkOutput("rst_idx", 64'(bus.data_idx_o), 64'd0);
          sbq.delete();
          bus.in_valid_i = 1'b0;
          aborted = 1'b1;
          @(negedge clk);
          reset = 1'b0;
        end else if (p == stallAt) begin
          for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.core_ready_i = 1'b0;
            #1;
            checkOutput("stall_ready", 64'(bus.in_ready_o), 64'd0);
            if (k > 0) checkOutput("stall_data_v", 64'(bus.data_v_o), 64'd0);
          end
        end
        p++;
      end
    end
    @(negedge clk);
    bus.in_valid_i   = 1'b0;
    bus.start_i      = 1'b0;
    bus.core_ready_i = 1'b1;
    if (aborted) return;
    checkOutput("bytes_fed", 64'(p), 64'(total));
    if (stray) begin
      checkOutput("stray_kk", 64'(bus.kk_o), 64'(kk));
      checkOutput("stray_ll", 64'(bus.ll_o), 64'(ll));
    end

    for (int w = 0; w < 400 && sbq.size() != 0; w++) @(negedge clk);
    repeat (3) @(negedge clk);
    checkOutput("beats_missing", 64'(sbq.size()), 64'd0);
    checkOutput("busy_wait_hash", 64'(bus.busy_o), 64'd1);

    for (int h = 0; h < nn; h++) begin
      @(negedge clk);
      bus.h_v_i = 1'b1;
      @(negedge clk);
      bus.h_v_i = 1'b0;
      #1;
      checkOutput("done_pulse", 64'(bus.done_o), 64'(h == nn - 1));
    end
    checkOutput("busy_after_done", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("done_one_cycle", 64'(bus.done_o), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    checkCount       = 0;
    errorCount       = 0;
    readyCount       = 0;
    reset            = 1'b0;
    bus.start_i      = 1'b0;
    bus.kk_i         = '0;
    bus.nn_i         = '0;
    bus.ll_i         = '0;
    bus.in_valid_i   = 1'b0;
    bus.in_data_i    = '0;
    bus.core_ready_i = 1'b1;
    bus.h_v_i        = 1'b0;

    #2 reset = 1'b1;
    #1;
    checkOutput("reset_busy", 64'(bus.busy_o), 64'd0);
    checkOutput("reset_data_v", 64'(bus.data_v_o), 64'd0);
    checkOutput("reset_ready", 64'(bus.in_ready_o), 64'd0);
    checkOutput("reset_done", 64'(bus.done_o), 64'd0);
    checkOutput("reset_cfg", 64'({bus.kk_o, bus.nn_o}), 64'd0);
    checkOutput("reset_flags", 64'({bus.block_first_o, bus.block_last_o}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    $display("[TB] empty message, no key");
    readyCount = 0;
    applyStimulus(0, 32, 0, -1, -1, 1'b0);
    checkOutput("pad_only_ready", 64'(readyCount), 64'd0);

    $display("[TB] abc and exact one-block message");
    applyStimulus(0, 8, 3, -1, -1, 1'b0);
    applyStimulus(0, 1, 64, -1, -1, 1'b0);

    $display("[TB] keyed three-block message with stray start");
    applyStimulus(16, 16, 100, -1, -1, 1'b1);

    $display("[TB] max key, empty message");
    applyStimulus(32, 4, 0, -1, -1, 1'b0);

    $display("[TB] core stall after idx 20");
    applyStimulus(0, 2, 100, 20, -1, 1'b0);

    $display("[TB] reset in MSG at idx 40, then restart");
    applyStimulus(0, 2, 100, -1, 40, 1'b0);
    applyStimulus(0, 3, 1, -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/blake2s_block_sched.md
BLAKE2S_BLOCK_SCHED -- requirements
Module: blake2s_block_sched

Interface
REQ-001 Parameter BLOCK_BYTES, default 64, bytes per BLAKE2s block.
REQ-002 Parameter LL_W, default 64, width of message-length field.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start_i  in  1  one-cycle pulse; latches kk_i/nn_i/ll_i, begins a hash.
REQ-006 kk_i  in  6  key length in bytes, 0..32.
REQ-007 nn_i  in  6  digest length in bytes, 1..32.
REQ-008 ll_i  in  LL_W  message length in bytes.
REQ-009 in_valid_i / in_data_i  in  1 / 8  input byte stream: key bytes first, then message bytes.
REQ-010 in_ready_o  out  1  input byte accepted when in_valid_i && in_ready_o.
REQ-011 core_ready_i  in  1  hash core can take a byte this cycle.
REQ-012 h_v_i  in  1  hash core emits one digest byte per pulse.
REQ-013 kk_o / nn_o / ll_o  out  6 / 6 / LL_W  latched configuration to core.
REQ-014 data_v_o / data_o / data_idx_o  out  1 / 8 / 6  byte beat to core, index within block.
REQ-015 block_first_o / block_last_o  out  1 / 1  level flags, stable over all 64 beats of a block.
REQ-016 busy_o / done_o  out  1 / 1  operation in progress / one-cycle completion pulse.

Function
REQ-017 States: IDLE, KEY, MSG, PAD, WAIT_HASH; the block SHALL leave IDLE only on start_i.
REQ-018 On start_i in IDLE: latch config, clear idx and counters, next state KEY if kk>0, MSG if kk==0 and ll>0, PAD if kk==0 and ll==0.
REQ-019 start_i outside IDLE SHALL be ignored.
REQ-020 in_ready_o = (state KEY or MSG) && core_ready_i, combinational; it SHALL be 0 in PAD, WAIT_HASH, IDLE.
REQ-021 Each accepted input byte, and each PAD cycle with core_ready_i=1, SHALL produce data_v_o=1 on the next clock with data_o (PAD: 0x00) and current data_idx_o; 1-cycle latency.
REQ-022 data_idx_o SHALL increment per beat and wrap 63->0; the wrap ends a block.
REQ-023 KEY: after kk bytes, go to PAD to zero-fill to idx 63; the key block is always a full block.
REQ-024 MSG: a 64-bit remaining counter, loaded with ll, SHALL decrement per accepted byte; at zero, go to PAD if idx!=0 after the beat, else the block is complete.
REQ-025 PAD exit at wrap: to MSG if remaining>0, else WAIT_HASH.
REQ-026 block_first_o=1 only for the first block; block_last_o=1 only for the block containing the final input byte, or the key block when ll==0, or the sole zero block when kk==ll==0.
REQ-027 ll multiple of 64 (ll>0) SHALL produce no PAD beats after the final message byte.
REQ-028 core_ready_i low SHALL stall: no beat, no counter change, flags held.
REQ-029 WAIT_HASH: count h_v_i pulses; on the nn-th, assert done_o for one cycle and return to IDLE.
REQ-030 busy_o=1 in every state except IDLE.

Reset
REQ-031 reset SHALL force IDLE asynchronously, mid-operation included; all outputs, counters and latched config SHALL read 0.
REQ-032 After reset deassertion, the first start_i SHALL be honoured.

Structure
REQ-033 Package blake2s_pkg SHALL hold BLOCK_BYTES, the key/digest max (32) and the state enumeration.
REQ-034 Single flat module; no sub-module. The block sits between the io interface and blake2s_hash256.

Verification
REQ-035 kk=0, ll=0, nn=32 -> 64 beats of 0x00, idx 0..63, first=last=1, in_ready never 1; 32 h_v_i -> done pulse.
REQ-036 kk=0, ll=3 ("abc") -> 3 data beats then 61 zero beats, first=last=1; ll=64 -> 64 beats, no pad.
REQ-037 kk=16, ll=100 -> block0 16 key + 48 zero (first=1, last=0); block1 64 msg; block2 36 msg + 28 zero (last=1).
REQ-038 kk=32, ll=0 -> one block of 32 key + 32 zero, first=last=1, then WAIT_HASH.
REQ-039 core_ready_i low 5 cycles after idx 20 -> no beats, in_ready 0, resume at idx 21 with the same flags.
REQ-040 reset pulse in MSG at idx 40 -> busy/data_v 0 immediately; a new start with kk=0, ll=1 -> first=last=1, 1 data + 63 zero beats.
